// File: rtl/regfile_write_queue_if.sv
// rtl/regfile_write_queue_if.sv - producer requests, register-file write port and status of the write queue
interface regfile_write_queue_if #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 8,
   parameter int ADDR_W = 2
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic                     a_valid;
   logic                     a_ready;
   logic [ADDR_W-1:0]        a_rd;
   logic [DATA_W-1:0]        a_data;
   logic                     b_valid;
   logic                     b_ready;
   logic [ADDR_W-1:0]        b_rd;
   logic [DATA_W-1:0]        b_data;
   logic                     wenabel;
   logic [ADDR_W-1:0]        rd;
   logic [DATA_W-1:0]        write_data;
   logic [(1<<ADDR_W)-1:0]   busy;
   logic [CNT_W-1:0]         count;
   logic                     full;
   logic                     empty;

   modport slave (
      input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
      output a_ready, b_ready, wenabel, rd, write_data, busy, count, full, empty
   );

   modport master (
      output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
      input  a_ready, b_ready, wenabel, rd, write_data, busy, count, full, empty
   );
endinterface

// File: rtl/regfile_write_queue.sv
// rtl/regfile_write_queue.sv - two-producer write-back FIFO serialising into the register file write port
module regfile_write_queue #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 8,
   parameter int ADDR_W = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   regfile_write_queue_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int NREG  = 1 << ADDR_W;

   logic [ADDR_W-1:0] r_rd_mem   [DEPTH];
   logic [DATA_W-1:0] r_data_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic              r_wen;
   logic [ADDR_W-1:0] r_rd;
   logic [DATA_W-1:0] r_wdata;

   logic              w_a_ready;
   logic              w_b_ready;
   logic              w_a_push;
   logic              w_b_push;
   logic              w_pop;
   logic [PTR_W-1:0]  w_b_ptr;
   logic [NREG-1:0]   w_busy;

   // B is younger, so it only gets the last free slot when A is not competing for it
   assign w_a_ready = !rst && (r_count <= CNT_W'(DEPTH - 1));
   assign w_b_ready = !rst && (bus.a_valid ? (r_count <= CNT_W'(DEPTH - 2))
                                           : (r_count <= CNT_W'(DEPTH - 1)));
   assign w_a_push  = bus.a_valid && w_a_ready;
   assign w_b_push  = bus.b_valid && w_b_ready;
   assign w_pop     = (r_count != '0);
   assign w_b_ptr   = r_wr_ptr + PTR_W'(w_a_push);

   always_ff @(posedge clk) begin
      if (w_a_push) begin
         r_rd_mem[r_wr_ptr]   <= bus.a_rd;
         r_data_mem[r_wr_ptr] <= bus.a_data;
      end
      if (w_b_push) begin
         r_rd_mem[w_b_ptr]    <= bus.b_rd;
         r_data_mem[w_b_ptr]  <= bus.b_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_wen    <= 1'b0;
         r_rd     <= '0;
         r_wdata  <= '0;
      end else begin
         r_wr_ptr <= r_wr_ptr + PTR_W'(w_a_push) + PTR_W'(w_b_push);
         r_count  <= r_count + CNT_W'(w_a_push) + CNT_W'(w_b_push) - CNT_W'(w_pop);
         r_wen    <= w_pop;
         if (w_pop) begin
            r_rd     <= r_rd_mem[r_rd_ptr];
            r_wdata  <= r_data_mem[r_rd_ptr];
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

   // An entry is live when its distance from the read pointer is below the occupancy
   always_comb begin
      w_busy = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if ({1'b0, PTR_W'(PTR_W'(i) - r_rd_ptr)} < r_count) begin
            w_busy[r_rd_mem[i]] = 1'b1;
         end
      end
      if (r_wen) begin
         w_busy[r_rd] = 1'b1;
      end
   end

   assign bus.a_ready    = w_a_ready;
   assign bus.b_ready    = w_b_ready;
   assign bus.wenabel    = r_wen;
   assign bus.rd         = r_rd;
   assign bus.write_data = r_wdata;
   assign bus.busy       = w_busy;
   assign bus.count      = r_count;
   assign bus.full       = (r_count == CNT_W'(DEPTH));
   assign bus.empty      = (r_count == '0);
endmodule

// File: tb/tb_regfile_write_queue.sv
// tb/tb_regfile_write_queue.sv - scoreboard bench for regfile_write_queue
module tb_regfile_write_queue;
   typedef struct {
      logic [1:0] rd;
      logic [7:0] data;
   } ent_t;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;
   ent_t sb[$];
   int   exp_cnt;
   bit   exp_wen;
   bit   acc_a;
   bit   acc_b;
   bit   mon_en;

   regfile_write_queue_if #(.DEPTH(4), .DATA_W(8), .ADDR_W(2)) bus ();

   regfile_write_queue #(.DEPTH(4), .DATA_W(8), .ADDR_W(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // occupancy model: one pop per edge while non-empty, pushes recorded by the driver
   always @(posedge clk) begin
      if (rst) begin
         exp_cnt = 0;
         exp_wen = 1'b0;
         sb.delete();
      end else begin
         exp_wen = (exp_cnt > 0);
         exp_cnt = exp_cnt + int'(acc_a) + int'(acc_b) - int'(exp_wen);
      end
      acc_a = 1'b0;
      acc_b = 1'b0;
   end

   always @(negedge clk) begin
      if (mon_en) begin
         logic [3:0] busy_exp;
         ent_t       e;
         busy_exp = '0;
         foreach (sb[i]) busy_exp[sb[i].rd] = 1'b1;
         chk("busy", 32'(bus.busy), 32'(busy_exp));
         chk("count", 32'(bus.count), 32'(exp_cnt));
         chk("full", 32'(bus.full), 32'(exp_cnt == 4));
         chk("empty", 32'(bus.empty), 32'(exp_cnt == 0));
         chk("wenabel", 32'(bus.wenabel), 32'(exp_wen));
         if (exp_wen) begin
            if (sb.size() == 0) begin
               chk("sb_underflow", 32'(1), 32'(0));
            end else begin
               e = sb.pop_front();
               chk("rd", 32'(bus.rd), 32'(e.rd));
               chk("write_data", 32'(bus.write_data), 32'(e.data));
            end
         end
      end
   end

   task automatic drive(input bit av, input logic [1:0] ard, input logic [7:0] ad,
                        input bit bv, input logic [1:0] brd, input logic [7:0] bd,
                        output bit got_a, output bit got_b);
      bit ear;
      bit ebr;
      @(negedge clk);
      bus.a_valid = av;
      bus.a_rd    = ard;
      bus.a_data  = ad;
      bus.b_valid = bv;
      bus.b_rd    = brd;
      bus.b_data  = bd;
      #1;
      ear = !rst && (exp_cnt <= 3);
      ebr = !rst && (av ? (exp_cnt <= 2) : (exp_cnt <= 3));
      chk("a_ready", 32'(bus.a_ready), 32'(ear));
      chk("b_ready", 32'(bus.b_ready), 32'(ebr));
      got_a = av && ear;
      got_b = bv && ebr;
      if (got_a) sb.push_back('{ard, ad});
      if (got_b) sb.push_back('{brd, bd});
      acc_a = got_a;
      acc_b = got_b;
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      bit ga;
      bit gb;
      for (int i = 0; i < n; i++) drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, ga, gb);
   endtask

   task automatic set_rst(input bit v);
      @(negedge clk);
      rst = v;
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b0;
      @(posedge clk);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || exp_cnt != 0) && n < 40) begin
         idle(1);
         n++;
      end
      idle(2);
      chk("drain_done", 32'(sb.size()), 32'(0));
   endtask

   initial begin
      bit   ga;
      bit   gb;
      int   na;
      int   nb;
      int   guard;
      bit   pa_v;
      bit   pb_v;
      logic [1:0] pa_rd;
      logic [1:0] pb_rd;
      logic [7:0] pa_d;
      logic [7:0] pb_d;

      vectors     = 0;
      miscompares = 0;
      exp_cnt     = 0;
      exp_wen     = 1'b0;
      acc_a       = 1'b0;
      acc_b       = 1'b0;
      mon_en      = 1'b0;
      rst         = 1'b1;
      bus.a_valid = 1'b0;
      bus.a_rd    = '0;
      bus.a_data  = '0;
      bus.b_valid = 1'b0;
      bus.b_rd    = '0;
      bus.b_data  = '0;

      // requests held during reset must be refused
      drive(1'b1, 2'd0, 8'h01, 1'b1, 2'd1, 8'h02, ga, gb);
      mon_en = 1'b1;
      drive(1'b1, 2'd0, 8'h01, 1'b1, 2'd1, 8'h02, ga, gb);
      set_rst(1'b0);
      idle(1);

      drive(1'b1, 2'd0, 8'hAA, 1'b0, 2'd0, 8'h00, ga, gb);
      idle(3);

      drive(1'b1, 2'd1, 8'h11, 1'b1, 2'd3, 8'hFE, ga, gb);
      idle(4);

      drive(1'b1, 2'd2, 8'h55, 1'b1, 2'd2, 8'h66, ga, gb);
      idle(4);

      // both producers pushing every cycle until ten of each are through
      na    = 0;
      nb    = 0;
      guard = 0;
      while ((na < 10 || nb < 10) && guard < 100) begin
         drive(na < 10, 2'(na), 8'h10 + 8'(na), nb < 10, 2'(nb + 1), 8'h80 + 8'(nb), ga, gb);
         if (ga) na++;
         if (gb) nb++;
         guard++;
      end
      chk("fill_accept", 32'(na + nb), 32'(20));
      drain();

      // three entries queued when reset hits
      drive(1'b1, 2'd1, 8'h01, 1'b1, 2'd2, 8'h02, ga, gb);
      drive(1'b1, 2'd3, 8'h03, 1'b1, 2'd0, 8'h04, ga, gb);
      set_rst(1'b1);
      set_rst(1'b0);
      idle(4);

      // random traffic with valid/data held until transfer
      pa_v = 1'b0;
      pb_v = 1'b0;
      pa_rd = '0;
      pb_rd = '0;
      pa_d  = '0;
      pb_d  = '0;
      for (int c = 0; c < 60; c++) begin
         if (!pa_v) begin
            pa_v  = 1'($urandom_range(0, 1));
            pa_rd = 2'($urandom_range(0, 3));
            pa_d  = 8'($urandom_range(0, 255));
         end
         if (!pb_v) begin
            pb_v  = 1'($urandom_range(0, 1));
            pb_rd = 2'($urandom_range(0, 3));
            pb_d  = 8'($urandom_range(0, 255));
         end
         drive(pa_v, pa_rd, pa_d, pb_v, pb_rd, pb_d, ga, gb);
         if (ga) pa_v = 1'b0;
         if (gb) pb_v = 1'b0;
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end
endmodule
